// File: rtl/mem_if.sv
// CPU-side memory bus: command, address and write data from the CPU;
// read data, read strobe and busy back from the responder.
interface mem_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [1:0]        m_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              busy;

  modport master (output m_cmd, mem_addr, write_data, input read_data, read_valid, busy);
  modport slave  (input m_cmd, mem_addr, write_data, output read_data, read_valid, busy);
endinterface

// File: rtl/mem_responder.sv
// Memory responder: services CPU reads/writes from on-chip RAM, an LED register
// and a synchronised switch port, with WAIT_CYC extra wait cycles per access.
module mem_responder #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                WAIT_CYC = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic       clk,
  input  logic       reset,
  mem_if.slave       bus,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic       err
);
  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [1:0]      CMD_R    = 2'b01;
  localparam logic [1:0]      CMD_W    = 2'b10;
  localparam logic [1:0]      CMD_X    = 2'b11;
  localparam logic [2:0]      CNT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              capture;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        sw_s1, sw_s2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              is_ram, is_led, is_sw, req_wr, dec_err, cmd_err;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: if (bus.m_cmd == CMD_R || bus.m_cmd == CMD_W) begin
        capture = 1'b1;
        if (WAIT_CYC == 0) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (cnt == 3'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 3'd1;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is frozen at capture so later bus activity cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_cmd   <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (capture) begin
      req_cmd   <= bus.m_cmd;
      req_addr  <= bus.mem_addr;
      req_wdata <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // RAM is not reset; an aborted access never reaches RESP so nothing is written.
  always_ff @(posedge clk) begin
    if (state == RESP && req_wr && is_ram) mem[req_addr[IDX_W-1:0]] <= req_wdata;
  end

  always_comb begin
    is_ram  = ({1'b0, req_addr} < DEPTH_L);
    is_led  = !is_ram && (req_addr == LED_ADDR);
    is_sw   = !is_ram && (req_addr == SW_ADDR);
    req_wr  = (req_cmd == CMD_W);
    dec_err = !(is_ram || is_led || is_sw) || (is_sw && req_wr);
    rd_word = '0;
    if (is_ram)      rd_word = mem[req_addr[IDX_W-1:0]];
    else if (is_led) rd_word = DATA_W'(led);
    else if (is_sw)  rd_word = DATA_W'(sw_s2);
    cmd_err = (state == IDLE) ? (bus.m_cmd == CMD_X) : (bus.m_cmd != 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
      led            <= '0;
      err            <= 1'b0;
    end else begin
      bus.read_valid <= 1'b0;
      if (cmd_err) err <= 1'b1;
      if (state == RESP) begin
        if (dec_err) err <= 1'b1;
        if (!req_wr) begin
          bus.read_valid <= 1'b1;
          bus.read_data  <= rd_word;
        end else if (is_led) begin
          led <= req_wdata[7:0];
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with no wait cycles and one with three,
// checked against an address-map reference model with directed and random accesses.
module tb_mem_responder;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led_f, led_s;
  logic       err_f, err_s;
  int         checks = 0;
  int         errors = 0;

  logic [15:0] ram_m [2][256];
  logic [7:0]  led_m [2];
  bit          err_m [2];
  logic [15:0] rd_m  [2];

  mem_if #(.ADDR_W(9), .DATA_W(16)) f ();
  mem_if #(.ADDR_W(9), .DATA_W(16)) s ();

  mem_responder #(.WAIT_CYC(0)) u_fast (.clk(clk), .reset(reset), .bus(f), .sw(sw), .led(led_f), .err(err_f));
  mem_responder #(.WAIT_CYC(3)) u_slow (.clk(clk), .reset(reset), .bus(s), .sw(sw), .led(led_s), .err(err_s));

  always #5 clk = ~clk;

  function automatic logic        busy_of(input bit sl); return sl ? s.busy       : f.busy;       endfunction
  function automatic logic        rv_of  (input bit sl); return sl ? s.read_valid : f.read_valid; endfunction
  function automatic logic [15:0] rd_of  (input bit sl); return sl ? s.read_data  : f.read_data;  endfunction
  function automatic logic [7:0]  led_of (input bit sl); return sl ? led_s        : led_f;        endfunction
  function automatic logic        err_of (input bit sl); return sl ? err_s        : err_f;        endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      led_m[i] = '0;
      err_m[i] = 1'b0;
      rd_m[i]  = '0;
    end
  endfunction

  // Address-map rules; returns the expected read word (0 for writes).
  function automatic logic [15:0] model_access(input bit sl, input logic [1:0] c,
                                               input logic [8:0] a, input logic [15:0] d);
    int          i = sl ? 1 : 0;
    logic [15:0] r = 16'h0000;
    if (a < 9'd256) begin
      if (c == W) ram_m[i][a[7:0]] = d;
      else        r = ram_m[i][a[7:0]];
    end else if (a == 9'h100) begin
      if (c == W) led_m[i] = d[7:0];
      else        r = {8'h00, led_m[i]};
    end else if (a == 9'h140) begin
      if (c == W) err_m[i] = 1'b1;
      else        r = {8'h00, sw};
    end else begin
      err_m[i] = 1'b1;
    end
    if (c == R) rd_m[i] = r;
    return r;
  endfunction

  task automatic drive(input bit sl, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    if (sl) begin
      s.m_cmd = c; s.mem_addr = a; s.write_data = d;
    end else begin
      f.m_cmd = c; f.mem_addr = a; f.write_data = d;
    end
  endtask

  task automatic reset_all();
    drive(0, 2'b00, '0, '0);
    drive(1, 2'b00, '0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One access from a negedge: lat = edges from capture to first read_valid sample.
  task automatic access(input bit sl, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int bc, output int rc, output bit tmo);
    bit done = 1'b0;
    lat = -1; bc = 0; rc = 0;
    drive(sl, c, a, d);
    @(posedge clk);
    @(negedge clk);
    drive(sl, 2'b00, 9'($urandom), 16'($urandom));
    for (int j = 0; j < 24 && !done; j++) begin
      if (busy_of(sl)) bc++;
      if (rv_of(sl)) begin
        rc++;
        if (lat < 0) lat = j;
      end
      if (!busy_of(sl) && j > 0) done = 1'b1;
      @(negedge clk);
    end
    if (rv_of(sl)) rc++;
    tmo = !done;
    rd  = rd_of(sl);
  endtask

  task automatic test_reset();
    sw = 8'h00;
    drive(0, 2'b00, '0, '0);
    drive(1, 2'b00, '0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (busy_of(1'(i)) !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_of(1'(i))); end
      checks++; if (rv_of(1'(i)) !== 1'b0) begin errors++; $display("FAIL reset_rv[%0d]: got %b want 0", i, rv_of(1'(i))); end
      checks++; if (rd_of(1'(i)) !== 16'h0) begin errors++; $display("FAIL reset_rd[%0d]: got %h want 0", i, rd_of(1'(i))); end
      checks++; if (led_of(1'(i)) !== 8'h0) begin errors++; $display("FAIL reset_led[%0d]: got %h want 0", i, led_of(1'(i))); end
      checks++; if (err_of(1'(i)) !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", i, err_of(1'(i))); end
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_fast_ram();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    void'(model_access(0, W, 9'd5, 16'hBEEF));
    access(0, W, 9'd5, 16'hBEEF, rd, lat, bc, rc, tmo);
    checks++; if (tmo || bc != 1) begin errors++; $display("FAIL fast_wr_busy: got %0d cycles (tmo %b) want 1", bc, tmo); end
    checks++; if (rc != 0) begin errors++; $display("FAIL fast_wr_rv: got %0d pulses want 0", rc); end
    exp = model_access(0, R, 9'd5, 16'h0);
    access(0, R, 9'd5, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || lat != 1) begin errors++; $display("FAIL fast_rd_lat: got %0d want 1", lat); end
    checks++; if (bc != 1) begin errors++; $display("FAIL fast_rd_busy: got %0d want 1", bc); end
    checks++; if (rc != 1) begin errors++; $display("FAIL fast_rd_rv: got %0d pulses want 1", rc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL fast_rd_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_slow_read();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    void'(model_access(1, W, 9'd0, 16'h1234));
    access(1, W, 9'd0, 16'h1234, rd, lat, bc, rc, tmo);
    checks++; if (tmo || bc != 4) begin errors++; $display("FAIL slow_wr_busy: got %0d want 4", bc); end
    exp = model_access(1, R, 9'd0, 16'h0);
    access(1, R, 9'd0, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || lat != 4) begin errors++; $display("FAIL slow_rd_lat: got %0d want 4", lat); end
    checks++; if (bc != 4) begin errors++; $display("FAIL slow_rd_busy: got %0d want 4", bc); end
    checks++; if (rc != 1) begin errors++; $display("FAIL slow_rd_rv: got %0d pulses want 1", rc); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL slow_rd_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_led();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    void'(model_access(0, W, 9'h100, 16'h00A5));
    access(0, W, 9'h100, 16'h00A5, rd, lat, bc, rc, tmo);
    checks++; if (led_f !== led_m[0]) begin errors++; $display("FAIL led_write: got %h want %h", led_f, led_m[0]); end
    checks++; if (rd !== rd_m[0]) begin errors++; $display("FAIL led_wr_rd_hold: got %h want %h", rd, rd_m[0]); end
    checks++; if (led_s !== led_m[1]) begin errors++; $display("FAIL led_other_inst: got %h want %h", led_s, led_m[1]); end
    exp = model_access(0, R, 9'h100, 16'h0);
    access(0, R, 9'h100, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || rd !== exp) begin errors++; $display("FAIL led_read: got %h want %h", rd, exp); end
  endtask

  task automatic test_switch();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp = model_access(1'(i), R, 9'h140, 16'h0);
      access(1'(i), R, 9'h140, 16'h0, rd, lat, bc, rc, tmo);
      checks++; if (tmo || rd !== exp) begin errors++; $display("FAIL sw_read[%0d]: got %h want %h", i, rd, exp); end
      checks++; if (err_of(1'(i)) !== err_m[i]) begin errors++; $display("FAIL sw_read_err[%0d]: got %b want %b", i, err_of(1'(i)), err_m[i]); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    reset_all();
    checks++; if (err_f !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_f); end
    void'(model_access(0, W, 9'h1FF, 16'hDEAD));
    access(0, W, 9'h1FF, 16'hDEAD, rd, lat, bc, rc, tmo);
    checks++; if (err_f !== err_m[0]) begin errors++; $display("FAIL err_bad_addr: got %b want %b", err_f, err_m[0]); end
    checks++; if (led_f !== led_m[0]) begin errors++; $display("FAIL err_led_kept: got %h want %h", led_f, led_m[0]); end
    checks++; if (rd !== rd_m[0]) begin errors++; $display("FAIL err_rd_kept: got %h want %h", rd, rd_m[0]); end

    // A read issued while the write is in flight is ignored but flagged.
    reset_all();
    void'(model_access(0, W, 9'd5, 16'h5555));
    drive(0, W, 9'd5, 16'h5555);
    @(posedge clk); @(negedge clk);
    drive(0, R, 9'd6, 16'h0);
    @(posedge clk); @(negedge clk);
    drive(0, 2'b00, '0, '0);
    err_m[0] = 1'b1;
    checks++; if (err_f !== err_m[0]) begin errors++; $display("FAIL err_busy_cmd: got %b want %b", err_f, err_m[0]); end
    checks++; if (busy_of(0) !== 1'b0 || rv_of(0) !== 1'b0) begin errors++; $display("FAIL busy_cmd_ignored: got busy %b rv %b want 0 0", busy_of(0), rv_of(0)); end

    reset_all();
    drive(0, 2'b11, 9'd5, 16'h0);
    @(posedge clk); @(negedge clk);
    drive(0, 2'b00, '0, '0);
    err_m[0] = 1'b1;
    checks++; if (err_f !== err_m[0] || busy_of(0) !== 1'b0) begin errors++; $display("FAIL err_illegal: got err %b busy %b want 1 0", err_f, busy_of(0)); end
    repeat (4) @(negedge clk);
    checks++; if (err_f !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_f); end
    exp = model_access(0, R, 9'd5, 16'h0);
    access(0, R, 9'd5, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || rd !== exp) begin errors++; $display("FAIL err_ram_kept: got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    reset_all();
    void'(model_access(1, W, 9'd9, 16'h1111));   access(1, W, 9'd9, 16'h1111, rd, lat, bc, rc, tmo);
    void'(model_access(1, W, 9'h100, 16'h005A)); access(1, W, 9'h100, 16'h005A, rd, lat, bc, rc, tmo);
    void'(model_access(1, W, 9'h1FF, 16'h0));    access(1, W, 9'h1FF, 16'h0, rd, lat, bc, rc, tmo);
    exp = model_access(1, R, 9'd9, 16'h0);
    access(1, R, 9'd9, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || rd !== exp || led_s !== led_m[1] || err_s !== err_m[1]) begin
      errors++; $display("FAIL abort_setup: got rd %h led %h err %b want %h %h %b", rd, led_s, err_s, exp, led_m[1], err_m[1]);
    end
    drive(1, W, 9'd9, 16'h7777);
    @(posedge clk); @(negedge clk);
    drive(1, 2'b00, '0, '0);
    @(posedge clk); @(negedge clk);
    checks++; if (busy_of(1) !== 1'b1) begin errors++; $display("FAIL abort_in_flight: got busy %b want 1", busy_of(1)); end
    reset = 1'b0;
    #1;
    checks++; if (s.busy !== 1'b0 || s.read_valid !== 1'b0) begin errors++; $display("FAIL abort_ctl: got busy %b rv %b want 0 0", s.busy, s.read_valid); end
    checks++; if (s.read_data !== 16'h0 || led_s !== 8'h0 || err_s !== 1'b0) begin
      errors++; $display("FAIL abort_regs: got rd %h led %h err %b want 0 0 0", s.read_data, led_s, err_s);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    exp = model_access(1, R, 9'd9, 16'h0);
    access(1, R, 9'd9, 16'h0, rd, lat, bc, rc, tmo);
    checks++; if (tmo || rd !== exp) begin errors++; $display("FAIL abort_no_commit: got %h want %h", rd, exp); end
    checks++; if (lat != 4) begin errors++; $display("FAIL abort_rd_lat: got %0d want 4", lat); end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp; int lat, bc, rc; bit tmo;
    logic [8:0]  bad [5] = '{9'h101, 9'h13F, 9'h141, 9'h1FF, 9'h180};
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++) begin
        logic [15:0] d = 16'($urandom);
        void'(model_access(1'(i), W, 9'(a), d));
        access(1'(i), W, 9'(a), d, rd, lat, bc, rc, tmo);
      end
    for (int n = 0; n < 60; n++) begin
      bit          sl   = 1'($urandom_range(0, 1));
      int          kind = $urandom_range(0, 9);
      int          wc   = sl ? 3 : 0;
      logic [1:0]  c    = W;
      logic [8:0]  a    = 9'($urandom_range(0, 15));
      logic [15:0] d    = 16'($urandom);
      sw = 8'($urandom);
      repeat (3) @(negedge clk);
      case (kind)
        0, 1, 2, 3: c = W;
        4, 5, 6:    c = R;
        7:          begin c = $urandom_range(0, 1) ? R : W; a = 9'h100; end
        8:          begin c = $urandom_range(0, 1) ? R : W; a = 9'h140; end
        default:    begin c = $urandom_range(0, 1) ? R : W; a = bad[$urandom_range(0, 4)]; end
      endcase
      exp = model_access(sl, c, a, d);
      access(sl, c, a, d, rd, lat, bc, rc, tmo);
      checks++; if (tmo || bc != wc + 1) begin errors++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", n, bc, wc + 1); end
      checks++; if (rc != (c == R ? 1 : 0)) begin errors++; $display("FAIL rnd_rv[%0d]: got %0d pulses cmd %b", n, rc, c); end
      if (c == R) begin
        checks++; if (lat != wc + 1) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, wc + 1); end
      end
      checks++; if (rd !== rd_m[sl]) begin errors++; $display("FAIL rnd_rd[%0d]: addr %h cmd %b got %h want %h", n, a, c, rd, rd_m[sl]); end
      checks++; if (led_of(sl) !== led_m[sl]) begin errors++; $display("FAIL rnd_led[%0d]: got %h want %h", n, led_of(sl), led_m[sl]); end
      checks++; if (err_of(sl) !== err_m[sl]) begin errors++; $display("FAIL rnd_err[%0d]: addr %h got %b want %b", n, a, err_of(sl), err_m[sl]); end
      if (c == R && rd_m[sl] !== exp) begin
        errors++; $display("FAIL rnd_model[%0d]: got %h want %h", n, rd_m[sl], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_ram();
    test_slow_read();
    test_led();
    test_switch();
    test_errors();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
